// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
// Module   : branch_predictor
// Function : Direct-mapped BTB with 2-bit saturating counters, plus EX-stage
//            branch resolution, mispredict/redirect and performance counters.
// Revision : 1.0 - initial release
// ============================================================================
module branch_predictor #(
  parameter int ENTRY_NUM = 64,
  parameter int INDEX_W   = 6
) (
  input  logic        CPU_CLK,
  input  logic        CPU_RST,
  input  logic [31:0] PC_F,
  output logic        PredTaken_F,
  output logic [31:0] PredTarget_F,
  input  logic        Valid_E,
  input  logic [2:0]  BranchType_E,
  input  logic [31:0] Operand1_E,
  input  logic [31:0] Operand2_E,
  input  logic [31:0] PC_E,
  input  logic [31:0] Target_E,
  input  logic        PredTaken_E,
  input  logic [31:0] PredTarget_E,
  output logic        Branch_E,
  output logic        Mispredict_E,
  output logic [31:0] Redirect_E,
  output logic [31:0] BranchCount,
  output logic [31:0] MissCount
);

  localparam int TAG_W = 32 - INDEX_W - 2;

  localparam logic [2:0] c_BEQ  = 3'd1;
  localparam logic [2:0] c_BNE  = 3'd2;
  localparam logic [2:0] c_BLT  = 3'd3;
  localparam logic [2:0] c_BLTU = 3'd4;
  localparam logic [2:0] c_BGE  = 3'd5;
  localparam logic [2:0] c_BGEU = 3'd6;

  logic [ENTRY_NUM-1:0] r_valid;
  logic [TAG_W-1:0]     r_tag    [ENTRY_NUM];
  logic [31:0]          r_target [ENTRY_NUM];
  logic [1:0]           r_cnt    [ENTRY_NUM];
  logic [31:0]          r_branch_count;
  logic [31:0]          r_miss_count;

  // ---------------------------------------------------------------- fetch
  logic [INDEX_W-1:0] w_f_idx;
  logic [TAG_W-1:0]   w_f_tag;
  logic               w_f_hit;

  assign w_f_idx = PC_F[INDEX_W+1:2];
  assign w_f_tag = PC_F[31:INDEX_W+2];
  assign w_f_hit = r_valid[w_f_idx] && (r_tag[w_f_idx] == w_f_tag);

  assign PredTaken_F  = w_f_hit && r_cnt[w_f_idx][1];
  assign PredTarget_F = PredTaken_F ? r_target[w_f_idx] : PC_F + 32'd4;

  // -------------------------------------------------------------- execute
  logic               w_cond;
  logic               w_is_branch;
  logic [INDEX_W-1:0] w_e_idx;
  logic [TAG_W-1:0]   w_e_tag;
  logic               w_e_hit;
  logic [1:0]         w_cnt_cur;
  logic [1:0]         w_cnt_next;
  logic               w_train;
  logic               w_alloc;
  logic               w_kill;
  logic               w_unused_pc_bits;

  assign w_unused_pc_bits = ^{PC_F[1:0], PC_E[1:0]};

  always_comb begin
    w_cond = 1'b0;
    case (BranchType_E)
      c_BEQ:   w_cond = (Operand1_E == Operand2_E);
      c_BNE:   w_cond = (Operand1_E != Operand2_E);
      c_BLT:   w_cond = ($signed(Operand1_E) <  $signed(Operand2_E));
      c_BLTU:  w_cond = (Operand1_E <  Operand2_E);
      c_BGE:   w_cond = ($signed(Operand1_E) >= $signed(Operand2_E));
      c_BGEU:  w_cond = (Operand1_E >= Operand2_E);
      default: w_cond = 1'b0;
    endcase
  end

  assign w_is_branch = Valid_E && (BranchType_E >= c_BEQ) && (BranchType_E <= c_BGEU);
  assign Branch_E    = w_is_branch && w_cond;
  assign Redirect_E  = Branch_E ? Target_E : PC_E + 32'd4;

  // Non-branch (including reserved code 7) predicted taken means a stale entry.
  always_comb begin
    Mispredict_E = 1'b0;
    if (w_is_branch) begin
      Mispredict_E = (Branch_E != PredTaken_E) ||
                     (Branch_E && (PredTarget_E != Target_E));
    end else if (Valid_E) begin
      Mispredict_E = PredTaken_E;
    end
  end

  assign w_e_idx   = PC_E[INDEX_W+1:2];
  assign w_e_tag   = PC_E[31:INDEX_W+2];
  assign w_e_hit   = r_valid[w_e_idx] && (r_tag[w_e_idx] == w_e_tag);
  assign w_cnt_cur = r_cnt[w_e_idx];

  always_comb begin
    w_cnt_next = w_cnt_cur;
    if (Branch_E) begin
      if (w_cnt_cur != 2'd3) w_cnt_next = w_cnt_cur + 2'd1;
    end else begin
      if (w_cnt_cur != 2'd0) w_cnt_next = w_cnt_cur - 2'd1;
    end
  end

  assign w_train = w_is_branch && w_e_hit;
  assign w_alloc = w_is_branch && !w_e_hit && Branch_E;
  assign w_kill  = Valid_E && !w_is_branch && PredTaken_E && w_e_hit;

  // ---------------------------------------------------------- table update
  always_ff @(posedge CPU_CLK or posedge CPU_RST) begin
    if (CPU_RST) begin
      r_valid <= '0;
      for (int i = 0; i < ENTRY_NUM; i++) begin
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_cnt[i]    <= 2'd1;
      end
    end else if (w_alloc) begin
      r_valid[w_e_idx]  <= 1'b1;
      r_tag[w_e_idx]    <= w_e_tag;
      r_target[w_e_idx] <= Target_E;
      r_cnt[w_e_idx]    <= 2'd2;
    end else if (w_train) begin
      r_cnt[w_e_idx] <= w_cnt_next;
      if (Branch_E) r_target[w_e_idx] <= Target_E;
    end else if (w_kill) begin
      r_valid[w_e_idx] <= 1'b0;
    end
  end

  // ------------------------------------------------- performance counters
  always_ff @(posedge CPU_CLK or posedge CPU_RST) begin
    if (CPU_RST) begin
      r_branch_count <= '0;
      r_miss_count   <= '0;
    end else begin
      if (w_is_branch)  r_branch_count <= r_branch_count + 32'd1;
      if (Mispredict_E) r_miss_count   <= r_miss_count + 32'd1;
    end
  end

  assign BranchCount = r_branch_count;
  assign MissCount   = r_miss_count;

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_predictor
// Function : Directed bench for branch_predictor with a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_predictor;

  localparam int ENTRY_NUM = 64;
  localparam int INDEX_W   = 6;

  localparam logic [2:0] NOBR = 3'd0, BEQ = 3'd1, BNE = 3'd2, BLT = 3'd3;
  localparam logic [2:0] BLTU = 3'd4, BGE = 3'd5, BGEU = 3'd6, RSVD = 3'd7;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] PC_F;
  logic        PredTaken_F;
  logic [31:0] PredTarget_F;
  logic        Valid_E;
  logic [2:0]  BranchType_E;
  logic [31:0] Operand1_E, Operand2_E, PC_E, Target_E, PredTarget_E;
  logic        PredTaken_E;
  logic        Branch_E, Mispredict_E;
  logic [31:0] Redirect_E, BranchCount, MissCount;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  branch_predictor #(.ENTRY_NUM(ENTRY_NUM), .INDEX_W(INDEX_W)) dut (
    .CPU_CLK(clk), .CPU_RST(rst), .PC_F(PC_F),
    .PredTaken_F(PredTaken_F), .PredTarget_F(PredTarget_F),
    .Valid_E(Valid_E), .BranchType_E(BranchType_E),
    .Operand1_E(Operand1_E), .Operand2_E(Operand2_E),
    .PC_E(PC_E), .Target_E(Target_E),
    .PredTaken_E(PredTaken_E), .PredTarget_E(PredTarget_E),
    .Branch_E(Branch_E), .Mispredict_E(Mispredict_E), .Redirect_E(Redirect_E),
    .BranchCount(BranchCount), .MissCount(MissCount)
  );

  // Behavioural model: table indexed by word address modulo table size.
  logic        m_valid  [ENTRY_NUM];
  logic [31:0] m_tag    [ENTRY_NUM];
  logic [31:0] m_target [ENTRY_NUM];
  int          m_cnt    [ENTRY_NUM];
  logic [31:0] m_bcount = 32'd0;
  logic [31:0] m_mcount = 32'd0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc / 32'd4) % ENTRY_NUM);
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] pc);
    return pc / (ENTRY_NUM * 4);
  endfunction

  function automatic logic outcome(input logic [2:0] t, input logic [31:0] a, input logic [31:0] b);
    case (t)
      BEQ:     return a == b;
      BNE:     return a != b;
      BLT:     return $signed(a) <  $signed(b);
      BLTU:    return a <  b;
      BGE:     return $signed(a) >= $signed(b);
      BGEU:    return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_br();
    return Valid_E && (BranchType_E inside {[3'd1:3'd6]});
  endfunction

  function automatic logic hit_at(input logic [31:0] pc);
    return m_valid[idx_of(pc)] && (m_tag[idx_of(pc)] == tag_of(pc));
  endfunction

  task automatic model_eval(output logic pt, output logic [31:0] ptg,
                            output logic br, output logic mis, output logic [31:0] red);
    pt  = hit_at(PC_F) && (m_cnt[idx_of(PC_F)] >= 2);
    ptg = pt ? m_target[idx_of(PC_F)] : PC_F + 32'd4;
    br  = is_br() && outcome(BranchType_E, Operand1_E, Operand2_E);
    red = br ? Target_E : PC_E + 32'd4;
    if (is_br()) mis = (br != PredTaken_E) || (br && (PredTarget_E != Target_E));
    else         mis = Valid_E && PredTaken_E;
  endtask

  always @(posedge clk or posedge rst) begin
    logic pt, br, mis;
    logic [31:0] ptg, red;
    int k;
    if (rst) begin
      for (int i = 0; i < ENTRY_NUM; i++) begin
        m_valid[i] = 1'b0; m_tag[i] = 32'd0; m_target[i] = 32'd0; m_cnt[i] = 1;
      end
      m_bcount = 32'd0;
      m_mcount = 32'd0;
    end else begin
      model_eval(pt, ptg, br, mis, red);
      k = idx_of(PC_E);
      if (is_br()) begin
        if (hit_at(PC_E)) begin
          m_cnt[k] = br ? ((m_cnt[k] + 1 > 3) ? 3 : m_cnt[k] + 1)
                        : ((m_cnt[k] - 1 < 0) ? 0 : m_cnt[k] - 1);
          if (br) m_target[k] = Target_E;
        end else if (br) begin
          m_valid[k] = 1'b1; m_tag[k] = tag_of(PC_E); m_target[k] = Target_E; m_cnt[k] = 2;
        end
        m_bcount = m_bcount + 32'd1;
      end else if (Valid_E && PredTaken_E && hit_at(PC_E)) begin
        m_valid[k] = 1'b0;
      end
      if (mis) m_mcount = m_mcount + 32'd1;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    logic pt, br, mis;
    logic [31:0] ptg, red;
    model_eval(pt, ptg, br, mis, red);
    check1 ("cyc PredTaken_F",  PredTaken_F,  pt);
    check32("cyc PredTarget_F", PredTarget_F, ptg);
    check1 ("cyc Branch_E",     Branch_E,     br);
    check1 ("cyc Mispredict_E", Mispredict_E, mis);
    check32("cyc Redirect_E",   Redirect_E,   red);
    check32("cyc BranchCount",  BranchCount,  m_bcount);
    check32("cyc MissCount",    MissCount,    m_mcount);
  end

  task automatic set_e(input logic v, input logic [2:0] t, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] pc, input logic [31:0] tgt, input logic pt, input logic [31:0] ptg);
    Valid_E = v; BranchType_E = t; Operand1_E = a; Operand2_E = b;
    PC_E = pc; Target_E = tgt; PredTaken_E = pt; PredTarget_E = ptg;
  endtask

  task automatic idle_e();
    set_e(1'b0, NOBR, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    PC_F = 32'h100;
    idle_e();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check1 ("rst PredTaken_F",  PredTaken_F,  1'b0);
    check32("rst PredTarget_F", PredTarget_F, 32'h104);
    check32("rst BranchCount",  BranchCount,  32'd0);

    // First taken branch allocates and is then predicted
    set_e(1'b1, BEQ, 32'd5, 32'd5, 32'h100, 32'h80, 1'b0, 32'h104);
    #1;
    check1 ("beq Branch_E",     Branch_E,     1'b1);
    check1 ("beq Mispredict_E", Mispredict_E, 1'b1);
    check32("beq Redirect_E",   Redirect_E,   32'h80);
    tick(); idle_e(); #1;
    check1 ("alloc PredTaken_F",  PredTaken_F,  1'b1);
    check32("alloc PredTarget_F", PredTarget_F, 32'h80);
    check32("alloc BranchCount",  BranchCount,  32'd1);
    check32("alloc MissCount",    MissCount,    32'd1);

    // Signed vs unsigned compares
    set_e(1'b1, BLT,  32'hFFFF_FFFF, 32'd1, 32'h404, 32'h500, 1'b0, 32'h408); #1;
    check1("blt Branch_E", Branch_E, 1'b1);
    tick();
    set_e(1'b1, BLTU, 32'hFFFF_FFFF, 32'd1, 32'h404, 32'h500, 1'b0, 32'h408); #1;
    check1("bltu Branch_E", Branch_E, 1'b0);
    tick();
    set_e(1'b1, BGEU, 32'hFFFF_FFFF, 32'd1, 32'h404, 32'h500, 1'b0, 32'h408); #1;
    check1("bgeu Branch_E", Branch_E, 1'b1);
    tick();

    // Counter saturation at 0x100
    repeat (3) begin
      set_e(1'b1, BEQ, 32'd7, 32'd7, 32'h100, 32'h80, 1'b1, 32'h80); tick();
    end
    set_e(1'b1, BNE, 32'd7, 32'd7, 32'h100, 32'h80, 1'b1, 32'h80); tick();
    idle_e(); #1;
    check1("sat1 PredTaken_F", PredTaken_F, 1'b1);
    repeat (2) begin
      set_e(1'b1, BNE, 32'd7, 32'd7, 32'h100, 32'h80, 1'b1, 32'h80); tick();
    end
    idle_e(); #1;
    check1 ("sat2 PredTaken_F",  PredTaken_F,  1'b0);
    check32("sat2 PredTarget_F", PredTarget_F, 32'h104);

    // Aliasing: 0x200 shares index 0 with 0x100
    set_e(1'b1, BEQ, 32'd1, 32'd1, 32'h200, 32'h300, 1'b0, 32'h204); tick();
    idle_e(); #1;
    check1 ("alias old PredTaken_F", PredTaken_F, 1'b0);
    PC_F = 32'h200; #1;
    check1 ("alias new PredTaken_F",  PredTaken_F,  1'b1);
    check32("alias new PredTarget_F", PredTarget_F, 32'h300);

    // Stale entry hit by a non-branch
    set_e(1'b1, NOBR, 32'd0, 32'd0, 32'h200, 32'h300, 1'b1, 32'h300); #1;
    check1 ("stale Branch_E",     Branch_E,     1'b0);
    check1 ("stale Mispredict_E", Mispredict_E, 1'b1);
    check32("stale Redirect_E",   Redirect_E,   32'h204);
    tick(); idle_e(); #1;
    check1("stale PredTaken_F", PredTaken_F, 1'b0);

    // Not-taken miss leaves the table alone
    PC_F = 32'h208;
    set_e(1'b1, BNE, 32'd3, 32'd3, 32'h208, 32'h900, 1'b0, 32'h20C); #1;
    check1 ("ntmiss Mispredict_E", Mispredict_E, 1'b0);
    check32("ntmiss Redirect_E",   Redirect_E,   32'h20C);
    tick(); idle_e(); #1;
    check1("ntmiss PredTaken_F", PredTaken_F, 1'b0);

    // Same index in F and E: lookup sees pre-edge contents
    PC_F = 32'h500;
    set_e(1'b1, BGE, 32'd5, 32'd3, 32'h500, 32'h40, 1'b0, 32'h504); #1;
    check1("nobypass PredTaken_F", PredTaken_F, 1'b0);
    tick(); idle_e(); #1;
    check1 ("post PredTaken_F",  PredTaken_F,  1'b1);
    check32("post PredTarget_F", PredTarget_F, 32'h40);

    // Reserved code and bubbles
    set_e(1'b1, RSVD, 32'd1, 32'd1, 32'h700, 32'h10, 1'b0, 32'h704); #1;
    check1("rsvd Branch_E", Branch_E, 1'b0);
    check1("rsvd Mispredict_E", Mispredict_E, 1'b0);
    tick();
    set_e(1'b0, BEQ, 32'd1, 32'd1, 32'h700, 32'h10, 1'b1, 32'h10); #1;
    check1("bubble Branch_E", Branch_E, 1'b0);
    check1("bubble Mispredict_E", Mispredict_E, 1'b0);
    tick(); idle_e(); #1;
    check32("tot BranchCount", BranchCount, 32'd13);
    check32("tot MissCount",   MissCount,   32'd9);

    // BranchCount wrap
    force dut.r_branch_count = 32'hFFFF_FFFF;
    m_bcount = 32'hFFFF_FFFF;
    #1 release dut.r_branch_count;
    set_e(1'b1, BEQ, 32'd9, 32'd9, 32'h800, 32'h20, 1'b0, 32'h804); tick();
    idle_e(); #1;
    check32("wrap BranchCount", BranchCount, 32'd0);

    // Reset mid-cycle with a pending update
    PC_F = 32'h600;
    set_e(1'b1, BEQ, 32'd2, 32'd2, 32'h600, 32'h44, 1'b0, 32'h604);
    #2 rst = 1'b1;
    #1;
    check1 ("midrst PredTaken_F",  PredTaken_F,  1'b0);
    check32("midrst PredTarget_F", PredTarget_F, 32'h604);
    check32("midrst BranchCount",  BranchCount,  32'd0);
    check32("midrst MissCount",    MissCount,    32'd0);
    tick();
    idle_e(); rst = 1'b0; #1;
    check1("postrst PredTaken_F", PredTaken_F, 1'b0);
    set_e(1'b1, BEQ, 32'd2, 32'd2, 32'h600, 32'h44, 1'b0, 32'h604); tick();
    idle_e(); #1;
    check1 ("first PredTaken_F",  PredTaken_F,  1'b1);
    check32("first PredTarget_F", PredTarget_F, 32'h44);
    check32("first BranchCount",  BranchCount,  32'd1);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
